// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, request opcode
// bit positions, FSM state encoding and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;

  typedef enum logic {IDLE, WRITE} state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lane[0];
      SZ_WORD: is_misaligned = |lane;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and Dmem port bundle of the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_readData,
    output stall, rsp_valid, rsp_rdata, misalign,
           mem_address, mem_writeData, mem_memWrite, mem_memRead
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_readData,
    input  stall, rsp_valid, rsp_rdata, misalign,
           mem_address, mem_writeData, mem_memWrite, mem_memRead
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load lane extraction with sign/zero extension and
// store lane merge into the word read from Dmem.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][7:0] rd_l;
  logic [NUM_LANES-1:0][7:0] st_l;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign rd_l = rdata;

  always_comb begin
    ld_b    = rd_l[lane];
    ld_h    = lane[1] ? rdata[31:16] : rdata[15:0];
    ld_data = rdata;
    case (size)
      SZ_BYTE: ld_data = {{24{ld_b[7] & ~is_unsigned}}, ld_b};
      SZ_HALF: ld_data = {{16{ld_h[15] & ~is_unsigned}}, ld_h};
      default: ld_data = rdata;
    endcase
  end

  // Each byte lane either keeps the Dmem byte or takes the matching store byte.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] LN = 2'(k);
    logic       sel;
    logic [7:0] src;
    assign sel = (size == SZ_BYTE && lane == LN) || (size == SZ_HALF && lane[1] == LN[1]);
    assign src = (size == SZ_HALF) ? wdata[8*(k%2) +: 8] : wdata[7:0];
    assign st_l[k] = sel ? src : rd_l[k];
  end

  assign st_word = st_l;

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: aligned Dmem accesses, two-cycle read-modify-write
// for sub-word stores, registered extended load response and misalign flag.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  bus
);
  state_t      state, nxt;
  logic [31:0] merge_q, addr_q;
  logic        rsp_valid_q, misalign_q;
  logic [31:0] rsp_rdata_q;

  logic [1:0]  size;
  logic        is_store, is_unsigned, fault;
  logic        go, acc, sub_st;
  logic [31:0] word_addr, ld_data, st_word;

  assign size        = bus.req_op[1:0];
  assign is_store    = bus.req_op[OP_STORE];
  assign is_unsigned = bus.req_op[OP_UNSIGNED];
  assign fault       = is_misaligned(size, bus.req_addr[1:0]);
  assign word_addr   = {bus.req_addr[31:2], 2'b00};

  // Requests are only decoded in IDLE; in WRITE the inputs are the held copy.
  assign go     = (state == IDLE) && bus.req_valid;
  assign acc    = go && !fault;
  assign sub_st = acc && is_store && (size != SZ_WORD);

  lsu_align u_align (
    .size        (size),
    .is_unsigned (is_unsigned),
    .lane        (bus.req_addr[1:0]),
    .rdata       (bus.mem_readData),
    .wdata       (bus.req_wdata),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  always_comb begin
    nxt               = state;
    bus.stall         = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writeData = '0;
    bus.mem_memWrite  = 1'b0;
    bus.mem_memRead   = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          bus.mem_address = word_addr;
          if (is_store && size == SZ_WORD) begin
            bus.mem_memWrite  = 1'b1;
            bus.mem_writeData = bus.req_wdata;
          end else begin
            bus.mem_memRead = 1'b1;
          end
          if (sub_st) begin
            bus.stall = 1'b1;
            nxt       = WRITE;
          end
        end
      end
      WRITE: begin
        bus.mem_memWrite  = 1'b1;
        bus.mem_address   = addr_q;
        bus.mem_writeData = merge_q;
        nxt               = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      merge_q     <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (sub_st) begin
        merge_q <= st_word;
        addr_q  <= word_addr;
      end
      rsp_valid_q <= (go && !sub_st) || (state == WRITE);
      misalign_q  <= go && fault;
      rsp_rdata_q <= (acc && !is_store) ? ld_data : '0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a word-array reference memory and
// an arithmetic model of load extension and sub-word store merge.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if bus();
  load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  logic [31:0] dmem    [16];
  logic [31:0] ref_mem [16];

  assign bus.mem_readData = dmem[bus.mem_address[5:2]];
  always @(posedge clk) if (bus.mem_memWrite) dmem[bus.mem_address[5:2]] <= bus.mem_writeData;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit m_fault(input logic [3:0] op, input logic [31:0] a);
    int sz = int'(op[1:0]);
    if (sz == 3) return 1;
    if (sz == 1) return (a % 2) != 0;
    if (sz == 2) return (a % 4) != 0;
    return 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a);
    logic [31:0] w = ref_mem[a[5:2]];
    logic [31:0] v;
    int sz = int'(op[1:0]);
    bit uns = op[2];
    if (sz == 0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] wd);
    logic [31:0] w = ref_mem[a[5:2]];
    logic [31:0] mask;
    int sh;
    int sz = int'(op[1:0]);
    if (sz == 2) return wd;
    if (sz == 0) begin sh = 8 * (a % 4); mask = 32'hFF; end
    else begin sh = 16 * ((a % 4) / 2); mask = 32'hFFFF; end
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // Drives one request at posedge+1, checks the request-cycle Dmem port, the
  // optional write cycle, then the registered response.
  task automatic issue(input bit v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    bit f    = m_fault(op, a);
    bit st   = op[3];
    bit act  = v && !f;
    bit sw   = act && st && op[1:0] == 2'b10;
    bit sub  = act && st && op[1:0] != 2'b10;
    logic [31:0] exp_rd = (act && !st) ? m_load(op, a) : 32'h0;
    logic [31:0] neww   = m_store(op, a, wd);
    bus.req_valid = v; bus.req_op = op; bus.req_addr = a; bus.req_wdata = wd;
    #1;
    chk("req_stall", 32'(bus.stall), 32'(sub));
    chk("req_memRead", 32'(bus.mem_memRead), 32'(act && !sw));
    chk("req_memWrite", 32'(bus.mem_memWrite), 32'(sw));
    chk("req_address", bus.mem_address, act ? {a[31:2], 2'b00} : 32'h0);
    chk("req_writeData", bus.mem_writeData, sw ? wd : 32'h0);
    @(posedge clk); #1;
    if (sub) begin
      chk("wr_stall", 32'(bus.stall), 32'h0);
      chk("wr_memWrite", 32'(bus.mem_memWrite), 32'h1);
      chk("wr_memRead", 32'(bus.mem_memRead), 32'h0);
      chk("wr_address", bus.mem_address, {a[31:2], 2'b00});
      chk("wr_writeData", bus.mem_writeData, neww);
      chk("wr_rsp_early", 32'(bus.rsp_valid), 32'h0);
      ref_mem[a[5:2]] = neww;
      @(posedge clk); #1;
    end
    if (sw) ref_mem[a[5:2]] = neww;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(v));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("misalign", 32'(bus.misalign), 32'(v && f));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, 32'(bus.stall), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    chk({tag, "_misalign"}, 32'(bus.misalign), 32'h0);
    chk({tag, "_address"}, bus.mem_address, 32'h0);
    chk({tag, "_writeData"}, bus.mem_writeData, 32'h0);
    chk({tag, "_memWrite"}, 32'(bus.mem_memWrite), 32'h0);
    chk({tag, "_memRead"}, 32'(bus.mem_memRead), 32'h0);
  endtask

  initial begin
    logic [31:0] wd, a;
    logic [3:0]  op;
    for (int i = 0; i < 16; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[1] = 32'h8899AABB; ref_mem[1] = 32'h8899AABB;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    #1;
    chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(1, 4'b0000, 32'h5, 32'h0);          // lb
    chk("lb_value", bus.rsp_rdata, 32'hFFFFFFAA);
    issue(1, 4'b0100, 32'h5, 32'h0);          // lbu
    chk("lbu_value", bus.rsp_rdata, 32'h000000AA);
    issue(1, 4'b0001, 32'h6, 32'h0);          // lh
    chk("lh_value", bus.rsp_rdata, 32'hFFFF8899);
    issue(1, 4'b0101, 32'h6, 32'h0);          // lhu
    chk("lhu_value", bus.rsp_rdata, 32'h00008899);
    issue(1, 4'b0010, 32'h4, 32'h0);          // lw
    chk("lw_value", bus.rsp_rdata, 32'h8899AABB);
    issue(1, 4'b1000, 32'h7, 32'h12345677);   // sb
    issue(1, 4'b0010, 32'h4, 32'h0);
    chk("sb_then_lw", bus.rsp_rdata, 32'h7799AABB);
    issue(1, 4'b1001, 32'h5, 32'hCAFEF00D);   // misaligned sh
    issue(1, 4'b0010, 32'h6, 32'h0);          // misaligned lw
    issue(1, 4'b0011, 32'h8, 32'h0);          // illegal size load
    issue(1, 4'b1011, 32'h8, 32'h1);          // illegal size store
    chk("fault_mem_kept", dmem[1], 32'h7799AABB);
    issue(1, 4'b1010, 32'h8, 32'hDEADBEEF);   // sw
    issue(1, 4'b0010, 32'h8, 32'h0);          // lw, no bubble
    chk("sw_then_lw", bus.rsp_rdata, 32'hDEADBEEF);

    // Reset during the write cycle of an sb.
    bus.req_valid = 1'b1; bus.req_op = 4'b1000; bus.req_addr = 32'h9; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    chk("rst_wr_memWrite", 32'(bus.mem_memWrite), 32'h1);
    rst_n = 1'b0; bus.req_valid = 1'b0;
    #1;
    chk_quiet("rst_in_write");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mem_kept", dmem[2], ref_mem[2]);
    issue(1, 4'b0010, 32'h8, 32'h0);
    chk("after_rst_lw", bus.rsp_rdata, 32'hDEADBEEF);
    issue(1, 4'b1001, 32'hA, 32'h0000BEAD);
    issue(1, 4'b0100, 32'hB, 32'h0);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom);
      a  = 32'($urandom_range(0, 63));
      wd = $urandom;
      issue(($urandom % 8) != 0, op, a, wd);
    end

    for (int i = 0; i < 16; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
